// File: rtl/min_reduce_int16_stream.sv
`default_nettype none
// ============================================================================
//  Module   : min_reduce_int16_stream (with helper min_reduce_gt_cmp)
//  Purpose  : Streaming signed-minimum reduction. Folds each frame of
//             FRAME_LEN signed samples into one running minimum and presents
//             the minimum and its 0-based in-frame index on an output
//             valid/ready handshake. Ties keep the earliest sample.
//  Ports    : clk        - rising-edge clock
//             rst_n      - asynchronous active-low reset
//             flush      - synchronous discard of a partial frame (ignored
//                          while a result is presented)
//             in_valid   - in_data is valid
//             in_ready   - stage can accept a sample (low only in HOLD)
//             in_data    - signed sample
//             out_valid  - frame result is valid
//             out_ready  - consumer accepts the result
//             out_data   - signed minimum of the frame
//             out_index  - position of the selected minimum in the frame
//  Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  min_reduce_gt_cmp : signed a > b. IMPL_TYPE selects the implementation:
//  1 = sign-extended subtract, anything else = direct signed compare.
// ----------------------------------------------------------------------------
module min_reduce_gt_cmp #(
  parameter int WIDTH     = 16,
  parameter int IMPL_TYPE = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt
);

  generate
    if (IMPL_TYPE == 1) begin : g_sub
      // One extra bit keeps the difference exact even for 0x7FFF - 0x8000.
      logic [WIDTH:0] diff;
      assign diff = {a[WIDTH-1], a} - {b[WIDTH-1], b};
      assign gt   = ~diff[WIDTH] & (|diff);
    end else begin : g_direct
      assign gt = $signed(a) > $signed(b);
    end
  endgenerate

endmodule

module min_reduce_int16_stream #(
  parameter int WIDTH     = 16,
  parameter int FRAME_LEN = 4,
  parameter int IMPL_TYPE = 0,
  parameter int IDX_W     = $clog2(FRAME_LEN > 1 ? FRAME_LEN : 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_index
);

  // The counter reaches FRAME_LEN while a result is held, which needs one
  // bit more than the index itself.
  localparam int             CNT_W    = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc;
  logic [IDX_W-1:0] acc_idx;

  logic             gt;
  logic             last;
  logic [WIDTH-1:0] next_acc;
  logic [IDX_W-1:0] next_idx;

  assign in_ready = (state != HOLD);

  min_reduce_gt_cmp #(
    .WIDTH     (WIDTH),
    .IMPL_TYPE (IMPL_TYPE)
  ) u_gt (
    .a  (acc),
    .b  (in_data),
    .gt (gt)
  );

  // count is 0 in IDLE, so a single compare also covers FRAME_LEN == 1.
  assign last = (count == LAST_CNT);

  // Candidate accumulator after folding in the current sample. Strict
  // greater-than keeps the earlier sample on ties.
  always_comb begin
    next_acc = acc;
    next_idx = acc_idx;
    if (state == IDLE) begin
      next_acc = in_data;
      next_idx = '0;
    end else if (gt) begin
      next_acc = in_data;
      next_idx = count[IDX_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      acc       <= '0;
      acc_idx   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (flush) begin
            // A sample arriving with flush is dropped along with the frame.
            state <= IDLE;
            count <= '0;
          end else if (in_valid) begin
            acc     <= next_acc;
            acc_idx <= next_idx;
            count   <= count + CNT_W'(1);
            if (last) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_data  <= next_acc;
              out_index <= next_idx;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          // flush is deliberately ignored here so a result is never lost.
          if (out_ready) begin
            state     <= IDLE;
            count     <= '0;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_min_reduce_int16_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_min_reduce_int16_stream
//  Purpose  : Self-checking bench for min_reduce_int16_stream. Drives a
//             FRAME_LEN=4 and a FRAME_LEN=1 instance from the same stimulus
//             and compares both against a frame-buffer reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_min_reduce_int16_stream;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic        in_ready4, out_valid4;
  logic [15:0] out_data4;
  logic [1:0]  out_index4;
  logic        in_ready1, out_valid1;
  logic [15:0] out_data1;
  logic [0:0]  out_index1;

  int checks = 0;
  int errors = 0;

  min_reduce_int16_stream #(.WIDTH(16), .FRAME_LEN(4), .IMPL_TYPE(0)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .in_data   (in_data),
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .out_data  (out_data4),
    .out_index (out_index4)
  );

  min_reduce_int16_stream #(.WIDTH(16), .FRAME_LEN(1), .IMPL_TYPE(0)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .in_data   (in_data),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_data  (out_data1),
    .out_index (out_index1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: store every accepted sample of the frame, and when the
  // frame is complete pick the smallest value, first occurrence winning.
  int                 fln [2] = '{4, 1};
  bit                 hold [2];
  bit                 ev [2];
  logic [15:0]        ed [2];
  int                 ei [2];
  int                 cnt [2];
  logic signed [15:0] fbuf [2][4];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      hold[k] = 1'b0;
      ev[k]   = 1'b0;
      ed[k]   = 16'h0000;
      ei[k]   = 0;
      cnt[k]  = 0;
    end
  endtask

  task automatic model_edge();
    logic signed [15:0] m;
    int                 mi;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      if (hold[k]) begin
        if (out_ready) begin
          hold[k] = 1'b0;
          ev[k]   = 1'b0;
        end
      end else if (flush) begin
        cnt[k] = 0;
      end else if (in_valid) begin
        fbuf[k][cnt[k]] = in_data;
        cnt[k]++;
        if (cnt[k] == fln[k]) begin
          m  = fbuf[k][0];
          mi = 0;
          for (int j = 1; j < fln[k]; j++)
            if (fbuf[k][j] < m) begin
              m  = fbuf[k][j];
              mi = j;
            end
          ed[k]   = m;
          ei[k]   = mi;
          ev[k]   = 1'b1;
          hold[k] = 1'b1;
          cnt[k]  = 0;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic compare_all();
    check("in_ready4",  {31'd0, in_ready4},  {31'd0, !hold[0]});
    check("out_valid4", {31'd0, out_valid4}, {31'd0, ev[0]});
    check("out_data4",  {16'd0, out_data4},  {16'd0, ed[0]});
    check("out_index4", {30'd0, out_index4}, ei[0]);
    check("in_ready1",  {31'd0, in_ready1},  {31'd0, !hold[1]});
    check("out_valid1", {31'd0, out_valid1}, {31'd0, ev[1]});
    check("out_data1",  {16'd0, out_data1},  {16'd0, ed[1]});
    check("out_index1", {31'd0, out_index1}, ei[1]);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic f, input logic r);
    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_ready = r;
    step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid4"}, {31'd0, out_valid4}, 32'd0);
    check({tag, "_data4"},  {16'd0, out_data4},  32'd0);
    check({tag, "_index4"}, {30'd0, out_index4}, 32'd0);
    check({tag, "_ready4"}, {31'd0, in_ready4},  32'd1);
    check({tag, "_valid1"}, {31'd0, out_valid1}, 32'd0);
    check({tag, "_data1"},  {16'd0, out_data1},  32'd0);
    check({tag, "_ready1"}, {31'd0, in_ready1},  32'd1);
  endtask

  function automatic logic [15:0] rand_sample();
    case ($urandom_range(0, 9))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2, 3:    return 16'($urandom_range(0, 3)) - 16'd1;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b1;
    model_reset();
    repeat (3) step();
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Basic frame
    drive(1'b1, 16'd5,    1'b0, 1'b1);
    drive(1'b1, 16'hFFFD, 1'b0, 1'b1);
    drive(1'b1, 16'd7,    1'b0, 1'b1);
    drive(1'b1, 16'd2,    1'b0, 1'b1);
    check("basic_valid", {31'd0, out_valid4}, 32'd1);
    check("basic_data",  {16'd0, out_data4},  32'h0000FFFD);
    check("basic_index", {30'd0, out_index4}, 32'd1);
    check("basic_ready", {31'd0, in_ready4},  32'd0);
    drive(1'b0, 16'd0, 1'b0, 1'b1);
    check("basic_ready_back", {31'd0, in_ready4}, 32'd1);

    // Extremes and ties
    drive(1'b1, 16'h7FFF, 1'b0, 1'b1);
    drive(1'b1, 16'h8000, 1'b0, 1'b1);
    drive(1'b1, 16'h8000, 1'b0, 1'b1);
    drive(1'b1, 16'h0000, 1'b0, 1'b1);
    check("ext_data",  {16'd0, out_data4},  32'h00008000);
    check("ext_index", {30'd0, out_index4}, 32'd1);
    drive(1'b0, 16'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 16'd9, 1'b0, 1'b1);
    check("tie_data",  {16'd0, out_data4},  32'd9);
    check("tie_index", {30'd0, out_index4}, 32'd0);
    drive(1'b0, 16'd0, 1'b0, 1'b1);

    // Backpressure
    drive(1'b1, 16'd1, 1'b0, 1'b0);
    drive(1'b1, 16'd2, 1'b0, 1'b0);
    drive(1'b1, 16'd3, 1'b0, 1'b0);
    drive(1'b1, 16'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(i[0], 16'($urandom), 1'b0, 1'b0);
      check("bp_valid", {31'd0, out_valid4}, 32'd1);
      check("bp_data",  {16'd0, out_data4},  32'd0);
      check("bp_index", {30'd0, out_index4}, 32'd3);
      check("bp_ready", {31'd0, in_ready4},  32'd0);
    end
    drive(1'b0, 16'd0, 1'b0, 1'b1);
    check("bp_release_ready", {31'd0, in_ready4}, 32'd1);
    check("bp_release_valid", {31'd0, out_valid4}, 32'd0);

    // Flush with a coincident sample, then a clean frame
    drive(1'b1, 16'd4,    1'b0, 1'b1);
    drive(1'b1, 16'hFFF8, 1'b0, 1'b1);
    drive(1'b1, 16'hFF9C, 1'b1, 1'b1);
    drive(1'b1, 16'd6,    1'b0, 1'b1);
    drive(1'b1, 16'd1,    1'b0, 1'b1);
    drive(1'b1, 16'd3,    1'b0, 1'b1);
    drive(1'b1, 16'd2,    1'b0, 1'b1);
    check("flush_data",  {16'd0, out_data4},  32'd1);
    check("flush_index", {30'd0, out_index4}, 32'd1);
    drive(1'b0, 16'd0, 1'b0, 1'b1);

    // Flush while holding a result
    drive(1'b1, 16'hFFFB, 1'b0, 1'b0);
    drive(1'b1, 16'd6,    1'b0, 1'b0);
    drive(1'b1, 16'd7,    1'b0, 1'b0);
    drive(1'b1, 16'd8,    1'b0, 1'b0);
    drive(1'b0, 16'd0,    1'b1, 1'b0);
    check("hold_flush_valid", {31'd0, out_valid4}, 32'd1);
    check("hold_flush_data",  {16'd0, out_data4},  32'h0000FFFB);
    drive(1'b0, 16'd0, 1'b0, 1'b1);
    check("hold_flush_done", {31'd0, out_valid4}, 32'd0);

    // Async reset mid-frame
    drive(1'b1, 16'd10, 1'b0, 1'b1);
    drive(1'b1, 16'd11, 1'b0, 1'b1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("arst_frame");
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset while holding
    drive(1'b1, 16'd1, 1'b0, 1'b0);
    drive(1'b1, 16'd2, 1'b0, 1'b0);
    drive(1'b1, 16'd3, 1'b0, 1'b0);
    drive(1'b1, 16'd4, 1'b0, 1'b0);
    check("pre_arst_valid", {31'd0, out_valid4}, 32'd1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("arst_hold");
    @(negedge clk);
    rst_n = 1'b1;

    drive(1'b1, 16'd10, 1'b0, 1'b1);
    drive(1'b1, 16'd20, 1'b0, 1'b1);
    drive(1'b1, 16'd30, 1'b0, 1'b1);
    drive(1'b1, 16'd40, 1'b0, 1'b1);
    check("post_arst_data",  {16'd0, out_data4},  32'd10);
    check("post_arst_index", {30'd0, out_index4}, 32'd0);
    drive(1'b0, 16'd0, 1'b0, 1'b1);

    // FRAME_LEN=1 instance
    drive(1'b1, 16'hFFFF, 1'b0, 1'b1);
    check("fl1_valid_a", {31'd0, out_valid1}, 32'd1);
    check("fl1_data_a",  {16'd0, out_data1},  32'h0000FFFF);
    check("fl1_index_a", {31'd0, out_index1}, 32'd0);
    check("fl1_ready_a", {31'd0, in_ready1},  32'd0);
    drive(1'b1, 16'd5, 1'b0, 1'b1);
    check("fl1_ready_b", {31'd0, in_ready1},  32'd1);
    check("fl1_valid_b", {31'd0, out_valid1}, 32'd0);
    drive(1'b1, 16'd5, 1'b0, 1'b1);
    check("fl1_data_c",  {16'd0, out_data1},  32'd5);
    check("fl1_index_c", {31'd0, out_index1}, 32'd0);
    drive(1'b0, 16'd0, 1'b0, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 3) != 0), rand_sample(),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
